// File: rtl/ex_csa_resolve.sv
// Sequential carry-propagate resolver: turns a carry-save pair (P + 2Q)
// into a plain binary sum, CHUNK bits per cycle.
module ex_csa_resolve #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] valP,
  input  logic [WIDTH-1:0] valQ,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH+1:0] valR,
  output logic             busy
);

  localparam int RW  = WIDTH + 2;
  localparam int NCH = (RW + CHUNK - 1) / CHUNK;
  localparam int PW  = NCH * CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_a;
  logic [PW-1:0]   r_b;
  logic [RW-1:0]   r_res;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;

  logic            w_acc;
  logic            w_c;
  logic [CHUNK-1:0] w_s;

  assign inReady  = reset &
                    ((r_state == IDLE) |
                     ((r_state == DONE) & outReady));
  assign busy     = (r_state == RUN);
  assign outValid = (r_state == DONE);
  assign valR     = r_res;
  assign w_acc    = inValid & inReady;

  // Operands shift down so the active chunk is always at bit 0.
  assign {w_c, w_s} = {1'b0, r_a[CHUNK-1:0]}
                    + {1'b0, r_b[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, r_carry};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (w_acc) begin
            r_a     <= PW'(valP);
            r_b     <= PW'({valQ, 1'b0});
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_state <= RUN;
          end else if (r_state == DONE && outReady) begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_c;
          r_res   <= r_res |
                     RW'(PW'(w_s) << (32'(r_cnt) * CHUNK));
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(NCH - 1)) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
